// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: mux-select encodings,
// the shadow pipeline-stage record and the "stage writes register" test.
package fwd_pkg;

    // Widest register address the stage record can carry; narrower
    // addresses are zero-extended into it.
    localparam int MAX_REG_AW = 8;

    // EX operand mux select encodings.
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    // One shadow pipeline stage.
    typedef struct packed {
        logic                  valid;
        logic [MAX_REG_AW-1:0] dst;
        logic                  reg_write;
        logic                  is_load;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    // True when stage s will write register r. r0 never counts when it is
    // hard-wired to zero.
    function automatic logic stage_writes(input stage_t s,
                                          input logic [MAX_REG_AW-1:0] r,
                                          input bit zero_en);
        return s.valid && s.reg_write && (s.dst == r) && !(zero_en && (r == '0));
    endfunction

endpackage

// File: rtl/fwd_select.sv
// Per-operand forwarding select: compares one ID/EX source against the
// EX/MEM and MEM/WB destinations, EX/MEM (younger result) taking priority.
module fwd_select
    import fwd_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter bit ZERO_REG_EN = 1'b1
) (
    input  logic              idex_valid_i,
    input  logic [REG_AW-1:0] src_i,
    input  stage_t            exmem_i,
    input  stage_t            memwb_i,
    output logic [1:0]        sel_o
);

    logic [MAX_REG_AW-1:0] src_ext;
    // Load flags are not needed for forwarding decisions.
    logic                  unused_flags;

    assign src_ext      = MAX_REG_AW'(src_i);
    assign unused_flags = &{1'b0, exmem_i.is_load, memwb_i.is_load};

    // Priority mux select; a bubble in ID/EX never forwards.
    always_comb begin
        sel_o = FWD_RF;
        if (idex_valid_i) begin
            if (stage_writes(exmem_i, src_ext, ZERO_REG_EN)) begin
                sel_o = FWD_EXMEM;
            end else if (stage_writes(memwb_i, src_ext, ZERO_REG_EN)) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit. Keeps shadow ID/EX, EX/MEM and MEM/WB
// records, drives the EX operand mux selects, stalls on load-use hazards and
// counts stall cycles with saturation.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int REG_AW      = 4,
    parameter int NUM_SRC     = 2,
    parameter bit ZERO_REG_EN = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_src,
    input  logic [REG_AW-1:0]         id_dst,
    input  logic                      id_reg_write,
    input  logic                      id_is_load,
    input  logic                      flush,
    output logic                      stall,
    output logic [NUM_SRC*2-1:0]      fwd_sel,
    output logic [CNT_W-1:0]          stall_count
);

    stage_t                    idex_q, idex_d;
    stage_t                    exmem_q;
    stage_t                    memwb_q;
    logic [NUM_SRC*REG_AW-1:0] idex_src_q;
    logic [CNT_W-1:0]          stall_count_q, stall_count_d;
    logic                      load_use;

    // Load-use hazard: the load in ID/EX produces a register the ID
    // instruction reads. A flush kills the ID instruction, so no stall.
    always_comb begin
        load_use = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (stage_writes(idex_q, MAX_REG_AW'(id_src[k*REG_AW +: REG_AW]), ZERO_REG_EN)) begin
                load_use = 1'b1;
            end
        end
        stall = !flush && id_valid && idex_q.is_load && load_use;
    end

    // Next ID/EX record: the ID instruction, or a bubble on stall/flush.
    always_comb begin
        idex_d = STAGE_BUBBLE;
        if (!stall && !flush) begin
            idex_d.valid     = id_valid;
            idex_d.dst       = MAX_REG_AW'(id_dst);
            idex_d.reg_write = id_reg_write;
            idex_d.is_load   = id_is_load;
        end
    end

    // Saturating stall-cycle counter.
    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 1'b1;
        end
    end

    // Shadow pipeline advance; the MEM/WB record simply falls off the end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q        <= STAGE_BUBBLE;
            exmem_q       <= STAGE_BUBBLE;
            memwb_q       <= STAGE_BUBBLE;
            idex_src_q    <= '0;
            stall_count_q <= '0;
        end else begin
            idex_q        <= idex_d;
            exmem_q       <= idex_q;
            memwb_q       <= exmem_q;
            idex_src_q    <= id_src;
            stall_count_q <= stall_count_d;
        end
    end

    for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
        fwd_select #(
            .REG_AW      (REG_AW),
            .ZERO_REG_EN (ZERO_REG_EN)
        ) u_sel (
            .idex_valid_i (idex_q.valid),
            .src_i        (idex_src_q[k*REG_AW +: REG_AW]),
            .exmem_i      (exmem_q),
            .memwb_i      (memwb_q),
            .sel_o        (fwd_sel[2*k +: 2])
        );
    end

    assign stall_count = stall_count_q;

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The module SHALL have parameter REG_AW, default 4, meaning register-address width (2**REG_AW architectural registers).
REQ-002 The module SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (1..4).
REQ-003 The module SHALL have parameter ZERO_REG_EN, default 1, meaning register 0 is hard-wired zero and is never forwarded or stalled on.
REQ-004 The module SHALL have parameter CNT_W, default 16, meaning the stall-counter width.
REQ-005 The module SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The module SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 The module SHALL have port id_valid, input, 1 bit: the ID-stage instruction is real.
REQ-008 The module SHALL have port id_src, input, NUM_SRC*REG_AW bits: ID source registers, with operand k in bits [k*REG_AW +: REG_AW].
REQ-009 The module SHALL have port id_dst, input, REG_AW bits: ID destination register.
REQ-010 The module SHALL have port id_reg_write, input, 1 bit: the ID instruction writes id_dst.
REQ-011 The module SHALL have port id_is_load, input, 1 bit: the ID instruction is a memory load.
REQ-012 The module SHALL have port flush, input, 1 bit: kill the ID-stage instruction (taken branch).
REQ-013 The module SHALL have port stall, output, 1 bit: hold PC/IF/ID and insert a bubble into EX.
REQ-014 The module SHALL have port fwd_sel, output, NUM_SRC*2 bits: per-operand EX mux select (00 register file, 10 EX/MEM result, 01 MEM/WB result).
REQ-015 The module SHALL have port stall_count, output, CNT_W bits: saturating count of stall cycles.

Function
REQ-016 The module SHALL hold internal shadow stages ID/EX, EX/MEM and MEM/WB, each holding {valid, dst, reg_write, is_load}; ID/EX SHALL additionally hold the NUM_SRC sources.
REQ-017 Every cycle the stages SHALL advance ID/EX->EX/MEM->MEM/WB, and the contents of MEM/WB SHALL be discarded.
REQ-018 ID/EX SHALL load the ID inputs when stall=0 and flush=0, and SHALL load a bubble (valid=0) when stall=1 or flush=1.
REQ-019 A stage SHALL "write rK" only if valid=1, reg_write=1 and dst=K, and additionally K!=0 when ZERO_REG_EN=1.
REQ-020 fwd_sel for operand k SHALL equal 10 if EX/MEM writes ID/EX src[k]; otherwise 01 if MEM/WB writes it; otherwise 00. EX/MEM SHALL take priority.
REQ-021 fwd_sel SHALL be combinational from internal registers only (no input-to-output path), and SHALL be 00 for every operand when ID/EX valid=0.
REQ-022 stall SHALL be 1 iff flush=0, id_valid=1, ID/EX is_load=1, and ID/EX writes id_src[k] for some k (load-use hazard). The hazard SHALL last exactly one cycle, because the bubble clears ID/EX.
REQ-023 When flush=1 and a hazard are simultaneous, flush SHALL win: stall=0, a bubble enters ID/EX, and stall_count SHALL be unchanged.
REQ-024 stall_count SHALL increment by 1 on each clock edge where stall=1, and SHALL saturate at 2**CNT_W-1 with no wrap.
REQ-025 A forward of 10 from an EX/MEM stage with is_load=1 SHALL never occur, given that REQ-022 holds.
REQ-026 Duplicate sources (src[i]==src[j]) SHALL each receive identical fwd_sel values.

Reset
REQ-027 While rst_n=0, all stage valid bits, reg_write and is_load SHALL be 0, stall_count SHALL be 0, and hence stall=0 and fwd_sel=0; this SHALL take effect asynchronously and regardless of clk.
REQ-028 After reset deasserts mid-stream, the first real instruction SHALL see no forwarding from pre-reset instructions.

Structure
REQ-029 The fwd_sel encodings (FWD_RF=00, FWD_EXMEM=10, FWD_MEMWB=01) and the stage-record typedef SHALL live in a shared package, fwd_pkg.
REQ-030 The per-operand compare/priority logic SHALL be one sub-module, fwd_select, instantiated NUM_SRC times via generate.

Verification
REQ-031 Back-to-back add r1 then add r1,r1 (both regWrite) with r7 in MEM/WB SHALL yield fwd_sel=10,10.
REQ-032 An ori with src r3,r8, with EX/MEM dst r11 and MEM/WB dst r8 (both writing), SHALL yield fwd_sel operand0=00, operand1=01.
REQ-033 An lw r6 followed by a use of r6 SHALL give stall=1 for one cycle, stall_count 0->1, and the next EX cycle SHALL show fwd_sel=01 for r6.
REQ-034 A source of r0 while EX/MEM writes r0 (ZERO_REG_EN=1) SHALL yield fwd_sel=00 and stall=0.
REQ-035 flush=1 coincident with a load-use hazard SHALL give stall=0, a bubble in EX on the next cycle, and stall_count unchanged.
REQ-036 Asserting rst_n=0 mid-stream with pending forwards SHALL give fwd_sel=0, stall=0 and stall_count=0 immediately, before any clock edge.
